// File: rtl/cpu_run_ctrl_if.sv
// Bus bundle between the run controller and whatever sequences it (bench or host logic).
// slave is the controller side; master drives start/abort and the computer's memory bus.
interface cpu_run_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
);
    logic              start;
    logic              abort;
    logic              mw;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wd;

    logic              cpu_rst;
    logic              clk_en;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [DATA_W-1:0] result;
    logic [CNT_W-1:0]  cycle_count;

    modport slave (
        input  start, abort, mw, addr, wd,
        output cpu_rst, clk_en, busy, done, timeout, result, cycle_count
    );

    modport master (
        output start, abort, mw, addr, wd,
        input  cpu_rst, clk_en, busy, done, timeout, result, cycle_count
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run controller for the 16-bit single-cycle computer: reset hold, clock enable, cycle budget, result capture.
// Optional macro ADDR_MATCH_EN: only writes to OUT_ADDR end the run (otherwise the first store does).
module cpu_run_ctrl #(
    parameter int                DATA_W     = 16,
    parameter int                CNT_W      = 16,
    parameter int                RST_CYCLES = 2,
    parameter int                MAX_CYCLES = 1000,
    parameter logic [DATA_W-1:0] OUT_ADDR   = 16'h00FC
) (
    input  logic          clk,
    input  logic          rst,
    cpu_run_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESET,
        S_RUN,
        S_DONE
    } state_t;

    localparam int                RC_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RC_W-1:0]   RST_LOAD = RC_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]  MAX_LAST = CNT_W'(MAX_CYCLES - 1);

    state_t            state;
    logic [RC_W-1:0]   rst_cnt;
    logic              cpu_rst_q;
    logic              clk_en_q;
    logic              busy_q;
    logic              done_q;
    logic              timeout_q;
    logic [DATA_W-1:0] result_q;
    logic [CNT_W-1:0]  cycle_count_q;
    logic              write_hit;

`ifdef ADDR_MATCH_EN
    assign write_hit = bus.mw && (bus.addr == OUT_ADDR);
`else
    logic unused_addr;
    assign write_hit   = bus.mw;
    assign unused_addr = ^{bus.addr, OUT_ADDR};
`endif

    // abort outranks everything; a write on the budget's last edge still counts as a result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_IDLE;
            rst_cnt       <= '0;
            cpu_rst_q     <= 1'b1;
            clk_en_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            timeout_q     <= 1'b0;
            result_q      <= '0;
            cycle_count_q <= '0;
        end else if (bus.abort) begin
            state     <= S_IDLE;
            cpu_rst_q <= 1'b1;
            clk_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state         <= S_RESET;
                        rst_cnt       <= RST_LOAD;
                        cpu_rst_q     <= 1'b1;
                        clk_en_q      <= 1'b0;
                        busy_q        <= 1'b1;
                        done_q        <= 1'b0;
                        timeout_q     <= 1'b0;
                        result_q      <= '0;
                        cycle_count_q <= '0;
                    end
                end
                S_RESET: begin
                    if (rst_cnt == '0) begin
                        state     <= S_RUN;
                        cpu_rst_q <= 1'b0;
                        clk_en_q  <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt - RC_W'(1);
                    end
                end
                S_RUN: begin
                    cycle_count_q <= cycle_count_q + CNT_W'(1);
                    if (write_hit) begin
                        state    <= S_DONE;
                        result_q <= bus.wd;
                        done_q   <= 1'b1;
                        clk_en_q <= 1'b0;
                        busy_q   <= 1'b0;
                    end else if (cycle_count_q == MAX_LAST) begin
                        state     <= S_DONE;
                        timeout_q <= 1'b1;
                        clk_en_q  <= 1'b0;
                        busy_q    <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    cpu_rst_q <= 1'b1;
                    clk_en_q  <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.cpu_rst     = cpu_rst_q;
    assign bus.clk_en      = clk_en_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.timeout     = timeout_q;
    assign bus.result      = result_q;
    assign bus.cycle_count = cycle_count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Randomized bench for cpu_run_ctrl; outcomes come from a run-level model (earliest of write, budget, abort).
module tb_cpu_run_ctrl;

    localparam int          DATA_W     = 16;
    localparam int          CNT_W      = 16;
    localparam int          RST_CYCLES = 2;
    localparam int          MAX_CYCLES = 8;
    localparam logic [15:0] OUT_ADDR   = 16'h00FC;
    localparam logic [15:0] STRAY_ADDR = 16'h0010;
    localparam int          VW         = 5 + DATA_W + CNT_W;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    logic [VW-1:0] got;
    logic [VW-1:0] exp_v;

    cpu_run_ctrl_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    cpu_run_ctrl #(
        .DATA_W    (DATA_W),
        .CNT_W     (CNT_W),
        .RST_CYCLES(RST_CYCLES),
        .MAX_CYCLES(MAX_CYCLES),
        .OUT_ADDR  (OUT_ADDR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {cpu_rst, clk_en, busy, done, timeout, result, cycle_count}
    function automatic logic [VW-1:0] pack(input logic cr, input logic ce, input logic bz,
                                           input logic dn, input logic to,
                                           input logic [DATA_W-1:0] res, input int cnt);
        return {cr, ce, bz, dn, to, res, CNT_W'(cnt)};
    endfunction

    task automatic run_case(input string name, input int write_at, input logic [15:0] write_wd,
                            input int stray_at, input logic [15:0] stray_wd, input int abort_at);
        int               first_q;
        int               term;
        int               outcome;
        logic [15:0]      res;
        logic [VW-1:0]    final_v;

        first_q = 0;
        res     = '0;
        if (write_at > 0) begin
            first_q = write_at;
            res     = write_wd;
        end
`ifndef ADDR_MATCH_EN
        if (stray_at > 0 && (first_q == 0 || stray_at < first_q)) begin
            first_q = stray_at;
            res     = stray_wd;
        end
`endif
        term    = MAX_CYCLES;
        outcome = 1;
        if (first_q > 0 && first_q <= MAX_CYCLES) begin
            term    = first_q;
            outcome = 0;
        end
        if (abort_at > 0 && abort_at <= term) begin
            term    = abort_at;
            outcome = 2;
        end
        case (outcome)
            0:       final_v = pack(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, res, term);
            1:       final_v = pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, MAX_CYCLES);
            default: final_v = pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, abort_at - 1);
        endcase

        bus.start = 1'b1;
        bus.abort = 1'b0;
        bus.mw    = 1'b0;
        tick();
        bus.start = 1'b0;
        got   = {bus.cpu_rst, bus.clk_en, bus.busy, bus.done, bus.timeout, bus.result, bus.cycle_count};
        exp_v = pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, 0);
        checks++;
        if (got !== exp_v) begin
            failures++;
            $display("[TB] FAIL %s start_edge: got=%h expected=%h", name, got, exp_v);
        end

        for (int j = 1; j <= RST_CYCLES; j++) begin
            bus.start = 1'($urandom_range(0, 1));
            tick();
            bus.start = 1'b0;
            got = {bus.cpu_rst, bus.clk_en, bus.busy, bus.done, bus.timeout, bus.result, bus.cycle_count};
            if (j < RST_CYCLES) exp_v = pack(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, '0, 0);
            else                exp_v = pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, 0);
            checks++;
            if (got !== exp_v) begin
                failures++;
                $display("[TB] FAIL %s reset_edge%0d: got=%h expected=%h", name, j, got, exp_v);
            end
        end

        for (int i = 1; i <= term; i++) begin
            bus.mw    = (i == write_at) || (i == stray_at);
            bus.addr  = (i == write_at) ? OUT_ADDR : (i == stray_at) ? STRAY_ADDR : 16'($urandom);
            bus.wd    = (i == write_at) ? write_wd : (i == stray_at) ? stray_wd : 16'($urandom);
            bus.abort = (i == abort_at);
            bus.start = 1'($urandom_range(0, 1));
            tick();
            bus.mw    = 1'b0;
            bus.abort = 1'b0;
            bus.start = 1'b0;
            got = {bus.cpu_rst, bus.clk_en, bus.busy, bus.done, bus.timeout, bus.result, bus.cycle_count};
            exp_v = (i < term) ? pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, '0, i) : final_v;
            checks++;
            if (got !== exp_v) begin
                failures++;
                $display("[TB] FAIL %s run_edge%0d: got=%h expected=%h", name, i, got, exp_v);
            end
        end

        // stray stores after the run must not disturb the frozen outputs
        for (int h = 0; h < 3; h++) begin
            bus.mw   = 1'b1;
            bus.addr = OUT_ADDR;
            bus.wd   = 16'($urandom);
            tick();
            bus.mw = 1'b0;
            got = {bus.cpu_rst, bus.clk_en, bus.busy, bus.done, bus.timeout, bus.result, bus.cycle_count};
            checks++;
            if (got !== final_v) begin
                failures++;
                $display("[TB] FAIL %s hold%0d: got=%h expected=%h", name, h, got, final_v);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #12;
        got   = {bus.cpu_rst, bus.clk_en, bus.busy, bus.done, bus.timeout, bus.result, bus.cycle_count};
        exp_v = pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 0);
        checks++;
        if (got !== exp_v) begin
            failures++;
            $display("[TB] FAIL reset_asserted: got=%h expected=%h", got, exp_v);
        end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.mw   = 1'($urandom_range(0, 1));
            bus.addr = 16'($urandom);
            bus.wd   = 16'($urandom);
            tick();
            got = {bus.cpu_rst, bus.clk_en, bus.busy, bus.done, bus.timeout, bus.result, bus.cycle_count};
            checks++;
            if (got !== exp_v) begin
                failures++;
                $display("[TB] FAIL idle%0d: got=%h expected=%h", k, got, exp_v);
            end
        end
        bus.mw = 1'b0;
    endtask

    task automatic test_normal();
        run_case("normal", 5, 16'h002A, 0, 16'h0, 0);
    endtask

    task automatic test_restart();
        run_case("restart", 2, 16'hBEEF, 0, 16'h0, 0);
    endtask

    task automatic test_timeout();
        run_case("timeout", 0, 16'h0, 0, 16'h0, 0);
        run_case("timeout_vs_write", MAX_CYCLES, 16'h5A5A, 0, 16'h0, 0);
    endtask

    task automatic test_abort();
        run_case("abort", 0, 16'h0, 0, 16'h0, 4);
        run_case("abort_vs_write", 3, 16'h1234, 0, 16'h0, 3);
    endtask

    task automatic test_addr_match();
        run_case("addr_match", 3, 16'h0007, 1, 16'h1111, 0);
    endtask

    task automatic test_random();
        int w, s, a;
        for (int n = 0; n < 24; n++) begin
            w = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, MAX_CYCLES));
            s = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, MAX_CYCLES)) : 0;
            if (s == w) s = 0;
            a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, MAX_CYCLES)) : 0;
            run_case($sformatf("random%0d", n), w, 16'($urandom), s, 16'($urandom), a);
        end
    endtask

    task automatic test_async_reset();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < RST_CYCLES + 2; k++) tick();
        bus.mw   = 1'b1;
        bus.addr = OUT_ADDR;
        bus.wd   = 16'hC0DE;
        #2;
        rst = 1'b0;
        #1;
        got   = {bus.cpu_rst, bus.clk_en, bus.busy, bus.done, bus.timeout, bus.result, bus.cycle_count};
        exp_v = pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0, 0);
        checks++;
        if (got !== exp_v) begin
            failures++;
            $display("[TB] FAIL async_reset_now: got=%h expected=%h", got, exp_v);
        end
        tick();
        got = {bus.cpu_rst, bus.clk_en, bus.busy, bus.done, bus.timeout, bus.result, bus.cycle_count};
        checks++;
        if (got !== exp_v) begin
            failures++;
            $display("[TB] FAIL async_reset_held: got=%h expected=%h", got, exp_v);
        end
        bus.mw = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.mw    = 1'b0;
        bus.addr  = '0;
        bus.wd    = '0;
        test_reset();
        test_normal();
        test_restart();
        test_timeout();
        test_abort();
        test_addr_match();
        test_random();
        test_async_reset();
        run_case("after_async_reset", 1, 16'h0F0F, 0, 16'h0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
